// File: rtl/delay_add_pipe.sv
// Registered two-operand add with an independent delay line on each operand.
// Build option DELAY_ADD_PIPE_SAT_EN: saturate c to all-ones on carry-out instead of wrapping.
module delay_add_pipe #(
  parameter int WIDTH   = 4,
  parameter int A_DELAY = 0,
  parameter int B_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             c_valid
);

  if (A_DELAY > 64 || B_DELAY > 64) begin : g_bad_delay
    $error("delay_add_pipe: A_DELAY/B_DELAY above 64 is not supported");
  end

  function automatic logic [WIDTH-1:0] fold_sum(input logic [WIDTH:0] s);
`ifdef DELAY_ADD_PIPE_SAT_EN
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
    return s[WIDTH-1:0];
`endif
  endfunction

  logic [WIDTH-1:0] a_dly, b_dly;
  logic             a_vld, b_vld;

  // Operand a delay line: depth 0 is a straight wire into the adder
  if (A_DELAY == 0) begin : g_a_wire
    assign a_dly = a;
    assign a_vld = in_valid;
  end else begin : g_a_reg
    logic [A_DELAY-1:0][WIDTH-1:0] a_stg_q;
    logic [A_DELAY-1:0]            a_vld_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_stg_q <= '0;
        a_vld_q <= '0;
      end else if (en) begin
        a_stg_q[0] <= a;
        a_vld_q[0] <= in_valid;
        for (int k = 1; k < A_DELAY; k++) begin
          a_stg_q[k] <= a_stg_q[k-1];
          a_vld_q[k] <= a_vld_q[k-1];
        end
      end
    end
    assign a_dly = a_stg_q[A_DELAY-1];
    assign a_vld = a_vld_q[A_DELAY-1];
  end

  // Operand b delay line, kept separate from a even when the depths match
  if (B_DELAY == 0) begin : g_b_wire
    assign b_dly = b;
    assign b_vld = in_valid;
  end else begin : g_b_reg
    logic [B_DELAY-1:0][WIDTH-1:0] b_stg_q;
    logic [B_DELAY-1:0]            b_vld_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        b_stg_q <= '0;
        b_vld_q <= '0;
      end else if (en) begin
        b_stg_q[0] <= b;
        b_vld_q[0] <= in_valid;
        for (int k = 1; k < B_DELAY; k++) begin
          b_stg_q[k] <= b_stg_q[k-1];
          b_vld_q[k] <= b_vld_q[k-1];
        end
      end
    end
    assign b_dly = b_stg_q[B_DELAY-1];
    assign b_vld = b_vld_q[B_DELAY-1];
  end

  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] c_d, c_q;
  logic             c_valid_d, c_valid_q;

  always_comb begin
    sum_d     = {1'b0, a_dly} + {1'b0, b_dly};
    c_d       = fold_sum(sum_d);
    c_valid_d = a_vld & b_vld;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q       <= '0;
      c_valid_q <= 1'b0;
    end else if (en) begin
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
    end
  end

  assign c       = c_q;
  assign c_valid = c_valid_q;

endmodule
